// File: rtl/delay_gate2_if.sv
// Gate-cell pin bundle: two sampled inputs, the delay-modelled output pair and
// the pending-transition flag.
interface delay_gate2_if;
  logic A;
  logic B;
  logic Z;
  logic ZN;
  logic busy;

  modport master (output A, B, input Z, ZN, busy);
  modport slave  (input A, B, output Z, ZN, busy);
endinterface

// File: rtl/delay_gate2.sv
// Two-input AND2/NOR2/XOR2 cell with inertial rise/fall delay counted in clock
// edges; pulses shorter than the applicable delay never reach Z.
module delay_gate2 #(
  parameter int FUNC  = 0,
  parameter int Tpdlh = 1,
  parameter int Tpdhl = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  delay_gate2_if.slave gate
);

  generate
    if (FUNC < 0 || FUNC > 2) begin : g_bad_func
      $error("delay_gate2: FUNC must be 0 (AND2), 1 (NOR2) or 2 (XOR2)");
    end
    if (Tpdlh < 1 || Tpdlh > 255) begin : g_bad_tpdlh
      $error("delay_gate2: Tpdlh must be in 1..255");
    end
    if (Tpdhl < 1 || Tpdhl > 255) begin : g_bad_tpdhl
      $error("delay_gate2: Tpdhl must be in 1..255");
    end
  endgenerate

  // Terminal counts are D-1: the toggle lands on the D-th consecutive edge.
  localparam logic [7:0] DLH_M1 = 8'(Tpdlh - 1);
  localparam logic [7:0] DHL_M1 = 8'(Tpdhl - 1);
  localparam logic       RST_Z  = (FUNC == 1);

  logic       f;
  logic       z_q, z_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] lim;

  always_comb begin
    f = 1'b0;
    case (FUNC)
      0:       f = gate.A & gate.B;
      1:       f = ~(gate.A | gate.B);
      default: f = gate.A ^ gate.B;
    endcase
  end

  // Any edge where f agrees with Z clears the count, which is what rejects
  // short pulses; the f == Z test wins even on the would-be terminal edge.
  always_comb begin
    z_d   = z_q;
    cnt_d = '0;
    lim   = f ? DLH_M1 : DHL_M1;
    if (f != z_q) begin
      if (cnt_q == lim) z_d   = f;
      else              cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_q   <= RST_Z;
      cnt_q <= '0;
    end else begin
      z_q   <= z_d;
      cnt_q <= cnt_d;
    end
  end

  assign gate.Z    = z_q;
  assign gate.ZN   = ~z_q;
  // Held in reset nothing can be pending, so busy is masked while rst_n is low.
  assign gate.busy = rst_n & (f ^ z_q);

endmodule

// File: tb/tb_delay_gate2.sv
// Self-checking bench: AND2(5/7), NOR2 and XOR2 cells on a shared stimulus
// table, then pulse-rejection and reset-while-pending sequences on the AND2.
module tb_delay_gate2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  delay_gate2_if if_and ();
  delay_gate2_if if_nor ();
  delay_gate2_if if_xor ();

  delay_gate2 #(.FUNC(0), .Tpdlh(5), .Tpdhl(7)) u_and (.clk(clk), .rst_n(rst_n), .gate(if_and.slave));
  delay_gate2 #(.FUNC(1))                       u_nor (.clk(clk), .rst_n(rst_n), .gate(if_nor.slave));
  delay_gate2 #(.FUNC(2))                       u_xor (.clk(clk), .rst_n(rst_n), .gate(if_xor.slave));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int   e;
    logic a, b;
    logic z_and, busy_and, z_nor, z_xor;
  } seg_t;

  typedef struct {
    string tag;
    int    e;
    logic  all;
    logic  z_and, busy_and, z_nor, z_xor;
  } exp_t;

  exp_t sb[$];

  task automatic chk(string name, int e, logic act, logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at step %0d: got %b, want %b", name, e, act, req);
    end
  endtask

  task automatic set_in(logic a, logic b);
    if_and.A = a; if_and.B = b;
    if_nor.A = a; if_nor.B = b;
    if_xor.A = a; if_xor.B = b;
  endtask

  // Drive before the edge, queue the expectation, then compare #1 after it.
  task automatic step(string tag, int e, logic rst, logic a, logic b, logic all,
                      logic z_and, logic busy_and, logic z_nor, logic z_xor);
    exp_t x;
    @(negedge clk);
    rst_n = rst;
    set_in(a, b);
    sb.push_back('{tag, e, all, z_and, busy_and, z_nor, z_xor});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty at step %0d: got 0 entries, want 1", e);
    end else begin
      x = sb.pop_front();
      chk({x.tag, "_and_z"},    x.e, if_and.Z,    x.z_and);
      chk({x.tag, "_and_busy"}, x.e, if_and.busy, x.busy_and);
      chk({x.tag, "_and_zn"},   x.e, if_and.ZN,   ~x.z_and);
      if (x.all) begin
        chk({x.tag, "_nor_z"},    x.e, if_nor.Z,    x.z_nor);
        chk({x.tag, "_nor_busy"}, x.e, if_nor.busy, 1'b0);
        chk({x.tag, "_nor_zn"},   x.e, if_nor.ZN,   ~x.z_nor);
        chk({x.tag, "_xor_z"},    x.e, if_xor.Z,    x.z_xor);
        chk({x.tag, "_xor_busy"}, x.e, if_xor.busy, 1'b0);
        chk({x.tag, "_xor_zn"},   x.e, if_xor.ZN,   ~x.z_xor);
      end
    end
  endtask

  task automatic and_run(string tag, int n, logic rst, logic a, logic b, logic z, logic busy);
    for (int i = 0; i < n; i++) step(tag, i, rst, a, b, 1'b0, z, busy, 1'b0, 1'b0);
  endtask

  seg_t segs [7];

  initial begin
    // Each record holds from its edge up to the next record's edge.
    segs[0] = '{0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    segs[1] = '{10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    segs[2] = '{20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    segs[3] = '{24, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    segs[4] = '{40, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    segs[5] = '{46, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    segs[6] = '{52, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    set_in(1'b0, 1'b0);
    // Reset values: AND 0, NOR 1, XOR 0, nothing pending.
    for (int i = 0; i < 2; i++)
      step("reset", i, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int s = 0; s < 6; s++)
      for (int e = segs[s].e; e < segs[s+1].e; e++)
        step("main", e, 1'b1, segs[s].a, segs[s].b, 1'b1,
             segs[s].z_and, segs[s].busy_and, segs[s].z_nor, segs[s].z_xor);

    // Pulse rejection on AND2, Tpdlh=5, B held high.
    and_run("pr_rst",   1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    and_run("pr_idle",  2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    and_run("pr_p4",    4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    and_run("pr_gap",   3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    and_run("pr_p5",    4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    and_run("pr_p5end", 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset on the third counting edge, then a clean five-edge count.
    and_run("rm_rst0",  1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    and_run("rm_cnt",   2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    and_run("rm_rst",   1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    and_run("rm_rel",   4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    and_run("rm_tog",   2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
